// File: rtl/active_list_commit_pkg.sv
// Shared CPU width constants for the rename/commit pipeline registers and the active list.
package active_list_commit_pkg;

  localparam int DATA_W_C        = 32;
  localparam int REG_ADDR_W_C    = 5;
  localparam int PHYS_ADDR_W_C   = REG_ADDR_W_C + 1;
  localparam int FREE_LIST_W_C   = 3;
  localparam int AL_DEPTH_C      = 1 << FREE_LIST_W_C;

endpackage

// File: rtl/active_list_commit.sv
// In-order retirement buffer: rename allocates at the tail, writeback marks entries done,
// and the head retires one completed entry per cycle, returning its old physical register.
module active_list_commit
  import active_list_commit_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_W_C,
  parameter int REG_ADDR_WIDTH  = REG_ADDR_W_C,
  parameter int FREE_LIST_WIDTH = FREE_LIST_W_C
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_physical_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_old_physical_addr,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  input  logic                       wb_reg,
  input  logic [FREE_LIST_WIDTH-1:0] active_list_index,
  input  logic                       commit_stall,
  output logic                       commit_valid,
  output logic [REG_ADDR_WIDTH-1:0]  commit_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_physical_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_free_addr,
  output logic [FREE_LIST_WIDTH:0]   count
);

  localparam int DEPTH = 1 << FREE_LIST_WIDTH;
  localparam logic [FREE_LIST_WIDTH:0] DEPTH_C = (FREE_LIST_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH < 1 || REG_ADDR_WIDTH < 1 || FREE_LIST_WIDTH < 1) begin : g_bad_params
    $error("active_list_commit: widths must be positive");
  end

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0]           done_q, done_d;
  logic [FREE_LIST_WIDTH-1:0] head_q, head_d;
  logic [FREE_LIST_WIDTH-1:0] tail_q, tail_d;
  logic [FREE_LIST_WIDTH:0]   count_q, count_d;

  logic [REG_ADDR_WIDTH-1:0]  virt_q [DEPTH];
  logic [REG_ADDR_WIDTH:0]    phys_q [DEPTH];
  logic [REG_ADDR_WIDTH:0]    old_q  [DEPTH];

  logic                       commit_valid_q;
  logic [REG_ADDR_WIDTH-1:0]  commit_virt_q;
  logic [REG_ADDR_WIDTH:0]    commit_phys_q;
  logic [REG_ADDR_WIDTH:0]    commit_free_q;

  logic alloc_fire;
  logic wb_fire;
  logic commit_fire;

  assign alloc_ready = (count_q < DEPTH_C);
  assign alloc_index = tail_q;
  assign count       = count_q;

  // Flush squashes everything, so every event is gated by it. A completion aimed at the
  // slot being allocated this cycle sees an invalid entry and is dropped naturally.
  always_comb begin
    alloc_fire  = alloc_valid && alloc_ready && !flush;
    wb_fire     = wb_reg && valid_q[active_list_index] && !done_q[active_list_index] && !flush;
    commit_fire = valid_q[head_q] && done_q[head_q] && !commit_stall && !flush;

    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_fire) begin
        done_d[active_list_index] = 1'b1;
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_virt_q  <= '0;
      commit_phys_q  <= '0;
      commit_free_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_fire;
      if (commit_fire) begin
        commit_virt_q <= virt_q[head_q];
        commit_phys_q <= phys_q[head_q];
        commit_free_q <= old_q[head_q];
      end
    end
  end

  // Payload storage needs no reset: an entry is only read after its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      virt_q[tail_q] <= alloc_virtual_addr;
      phys_q[tail_q] <= alloc_physical_addr;
      old_q[tail_q]  <= alloc_old_physical_addr;
    end
  end

  assign commit_valid         = commit_valid_q;
  assign commit_virtual_addr  = commit_virt_q;
  assign commit_physical_addr = commit_phys_q;
  assign commit_free_addr     = commit_free_q;

endmodule

// File: tb/tb_active_list_commit.sv
// Scoreboard bench for active_list_commit: a queue-of-instructions model predicts retirements.
module tb_active_list_commit;
  import active_list_commit_pkg::*;

  localparam int RW    = REG_ADDR_W_C;
  localparam int PW    = RW + 1;
  localparam int FW    = FREE_LIST_W_C;
  localparam int DEPTH = 1 << FW;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [RW-1:0] alloc_virtual_addr;
  logic [PW-1:0] alloc_physical_addr;
  logic [PW-1:0] alloc_old_physical_addr;
  logic [FW-1:0] alloc_index;
  logic          wb_reg;
  logic [FW-1:0] active_list_index;
  logic          commit_stall;
  logic          commit_valid;
  logic [RW-1:0] commit_virtual_addr;
  logic [PW-1:0] commit_physical_addr;
  logic [PW-1:0] commit_free_addr;
  logic [FW:0]   count;

  active_list_commit dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush                   (flush),
    .alloc_valid             (alloc_valid),
    .alloc_ready             (alloc_ready),
    .alloc_virtual_addr      (alloc_virtual_addr),
    .alloc_physical_addr     (alloc_physical_addr),
    .alloc_old_physical_addr (alloc_old_physical_addr),
    .alloc_index             (alloc_index),
    .wb_reg                  (wb_reg),
    .active_list_index       (active_list_index),
    .commit_stall            (commit_stall),
    .commit_valid            (commit_valid),
    .commit_virtual_addr     (commit_virtual_addr),
    .commit_physical_addr    (commit_physical_addr),
    .commit_free_addr        (commit_free_addr),
    .count                   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight instructions in program order, each tagged with its slot index.
  typedef struct {
    int            idx;
    logic [RW-1:0] v;
    logic [PW-1:0] p;
    logic [PW-1:0] o;
    bit            done;
  } ent_t;

  typedef struct {
    logic [RW-1:0] v;
    logic [PW-1:0] p;
    logic [PW-1:0] o;
  } exp_t;

  ent_t live[$];
  exp_t expq[$];
  int   m_tail;
  int   tests;
  int   fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit fl, input bit av, input logic [RW-1:0] va,
                      input logic [PW-1:0] pa, input logic [PW-1:0] oa,
                      input bit wb, input int widx, input bit st);
    bit do_commit;
    bit can_alloc;
    @(negedge clk);
    flush                   = fl;
    alloc_valid             = av;
    alloc_virtual_addr      = va;
    alloc_physical_addr     = pa;
    alloc_old_physical_addr = oa;
    wb_reg                  = wb;
    active_list_index       = widx[FW-1:0];
    commit_stall            = st;
    #1;
    chk("alloc_ready", alloc_ready, live.size() < DEPTH);
    chk("alloc_index", alloc_index, m_tail);
    chk("count", count, live.size());
    if (fl) begin
      live.delete();
      m_tail = 0;
    end else begin
      do_commit = (live.size() > 0) && live[0].done && !st;
      can_alloc = live.size() < DEPTH;
      if (wb)
        foreach (live[i]) if (live[i].idx == widx) live[i].done = 1'b1;
      if (do_commit) begin
        expq.push_back('{live[0].v, live[0].p, live[0].o});
        void'(live.pop_front());
      end
      if (av && can_alloc) begin
        live.push_back('{m_tail, va, pa, oa, 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0, st);
  endtask

  task automatic alloc(input int va, input int pa, input int oa);
    step(0, 1, RW'(va), PW'(pa), PW'(oa), 0, 0, 0);
  endtask

  task automatic complete(input int idx, input bit st);
    step(0, 0, '0, '0, '0, 1, idx, st);
  endtask

  task automatic async_reset();
    @(negedge clk);
    flush = 1'b0; alloc_valid = 1'b0; wb_reg = 1'b0; commit_stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_alloc_index", alloc_index, 0);
    chk("rst_commit_virt", commit_virtual_addr, 0);
    chk("rst_commit_phys", commit_physical_addr, 0);
    chk("rst_commit_free", commit_free_addr, 0);
    live.delete();
    expq.delete();
    m_tail = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Each predicted retirement must appear on the very next edge, in order.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (commit_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("spurious_commit", commit_valid, 0);
      end else begin
        e = expq.pop_front();
        chk("commit_virt", commit_virtual_addr, e.v);
        chk("commit_phys", commit_physical_addr, e.p);
        chk("commit_free", commit_free_addr, e.o);
      end
    end else if (expq.size() != 0) begin
      chk("missing_commit", commit_valid, 1);
      void'(expq.pop_front());
    end
  end

  initial begin
    int pick;
    tests = 0; fails = 0; m_tail = 0;
    rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; wb_reg = 1'b0; commit_stall = 1'b0;
    alloc_virtual_addr = '0; alloc_physical_addr = '0; alloc_old_physical_addr = '0;
    active_list_index = '0;
    #3;
    chk("init_commit_valid", commit_valid, 0);
    chk("init_count", count, 0);
    chk("init_alloc_ready", alloc_ready, 1);
    chk("init_commit_free", commit_free_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three allocations, then out-of-order completion with the head last.
    alloc(1, 33, 1); alloc(2, 34, 2); alloc(3, 35, 3);
    idle(1, 0);
    chk("three_alloc_count", count, 3);
    complete(1, 0); complete(2, 0); idle(2, 0);
    complete(0, 0); idle(4, 0);
    chk("drained_count", count, 0);

    // Fill to depth from index 0, overflow attempt, then wrap.
    step(1, 0, '0, '0, '0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) alloc(i + 4, 40 + i, 8 + i);
    alloc(31, 63, 63);
    chk("full_ready", alloc_ready, 0);
    complete(0, 0); idle(1, 0);
    alloc(20, 50, 21);

    // Stall holds a done head for three cycles.
    complete(1, 0);
    idle(3, 1);
    idle(2, 0);

    // Flush beats simultaneous alloc and completion.
    step(1, 0, '0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) alloc(i, 10 + i, 20 + i);
    complete(1, 0); complete(2, 0);
    step(1, 1, 5'd9, 6'd9, 6'd9, 1, 3, 0);
    idle(1, 0);
    chk("post_flush_index", alloc_index, 0);

    // Completion to an invalid slot, then an asynchronous reset with a commit on the outputs.
    alloc(7, 17, 27); alloc(8, 18, 28);
    complete(6, 0); idle(1, 0);
    complete(0, 0); idle(1, 0);
    async_reset();
    alloc(9, 19, 29);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) async_reset();
      pick = $urandom_range(0, DEPTH - 1);
      if (live.size() > 0 && $urandom_range(0, 9) < 7)
        pick = live[$urandom_range(0, live.size() - 1)].idx;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
           RW'($urandom), PW'($urandom), PW'($urandom),
           $urandom_range(0, 1) == 1, pick, $urandom_range(0, 3) == 0);
    end

    // Drain whatever remains.
    for (int c = 0; c < 4 * DEPTH && live.size() > 0; c++) begin
      pick = live[0].idx;
      foreach (live[i]) if (!live[i].done) begin pick = live[i].idx; break; end
      complete(pick, 0);
    end
    idle(2, 0);
    chk("final_count", count, 0);
    chk("scoreboard_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/active_list_commit.md
ACTIVE_LIST_COMMIT -- requirements
Module: active_list_commit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width; carried for uniformity, no data stored.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, architectural (virtual) register address width.
REQ-003 Parameter FREE_LIST_WIDTH, default 3, active-list index width; depth is 2**FREE_LIST_WIDTH (8).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  squash every uncommitted entry.
REQ-007 alloc_valid  input  1  rename stage requests one entry.
REQ-008 alloc_ready  output  1  entry available (combinational: count < depth).
REQ-009 alloc_virtual_addr  input  REG_ADDR_WIDTH  destination architectural register.
REQ-010 alloc_physical_addr  input  REG_ADDR_WIDTH+1  newly mapped physical register.
REQ-011 alloc_old_physical_addr  input  REG_ADDR_WIDTH+1  previous mapping, freed at commit.
REQ-012 alloc_index  output  FREE_LIST_WIDTH  tail index given to the allocating instruction (combinational, equals tail).
REQ-013 wb_reg  input  1  completion strobe from the mem-to-wb pipeline register.
REQ-014 active_list_index  input  FREE_LIST_WIDTH  entry completed by wb_reg.
REQ-015 commit_stall  input  1  inhibit commit this cycle.
REQ-016 commit_valid  output  1  registered; one entry retired.
REQ-017 commit_virtual_addr  output  REG_ADDR_WIDTH  retired architectural register.
REQ-018 commit_physical_addr  output  REG_ADDR_WIDTH+1  retired physical register (new committed mapping).
REQ-019 commit_free_addr  output  REG_ADDR_WIDTH+1  physical register returned to free list.
REQ-020 count  output  FREE_LIST_WIDTH+1  occupied entries, 0..depth; empty = (count==0).

Function
REQ-021 Circular buffer: per-entry valid, done, virtual, physical, old physical; head and tail pointers FREE_LIST_WIDTH bits, wrap modulo depth.
REQ-022 Allocation fires when alloc_valid && alloc_ready: entry[tail] written valid=1, done=0; tail+1; no full-bypass even if a commit occurs the same cycle.
REQ-023 Completion: wb_reg with valid entry[active_list_index] sets done=1 at the edge; completion to an invalid entry or an already-done entry is ignored.
REQ-024 Commit fires when entry[head] valid && done && !commit_stall: next edge commit_valid=1 with entry fields, entry invalidated, head+1; otherwise commit_valid=0 at that edge.
REQ-025 Latency: wb_reg at edge N, head entry commits at edge N+1 (commit_valid visible after N+1); at most one commit per cycle, strictly in allocation order.
REQ-026 Simultaneous alloc and commit: count unchanged; alloc only → count+1; commit only → count-1.
REQ-027 Completion targeting the entry being allocated the same cycle is ignored (entry not yet valid).
REQ-028 Flush has priority over alloc, completion and commit: at the edge all valid/done cleared, head=tail=0, count=0, commit_valid=0.
REQ-029 Return of speculatively allocated physical registers after flush belongs to the rename table, not this block.
REQ-030 commit_stall holds all entries and pointers; completions still recorded.

Reset
REQ-031 rst_n low: all entries invalid, head=tail=0, count=0, commit_valid=0, commit_virtual_addr=0, commit_physical_addr=0, commit_free_addr=0, immediately and independent of clk.
REQ-032 Reset asserted mid-operation discards all entries; first alloc after release receives index 0.

Structure
REQ-033 Width constants (REG_ADDR_WIDTH, FREE_LIST_WIDTH, physical width REG_ADDR_WIDTH+1) belong in the shared CPU parameter header used by the pipeline registers.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Reset, alloc 3 entries (v=1/p=33/old=1, v=2/p=34/old=2, v=3/p=35/old=3) → alloc_index 0,1,2, count=3, commit_valid stays 0.
REQ-036 Complete index 1 then 2, then 0 → no commit until index 0 done; then commits v=1,2,3 on three consecutive edges, commit_free_addr 1,2,3, count 0.
REQ-037 Allocate 8 → alloc_ready=0, count=8; 9th alloc_valid ignored; complete index 0 → one commit, alloc_ready=1, next alloc gets index 0 (wrap).
REQ-038 Head done with commit_stall=1 for 3 cycles → commit_valid=0, count unchanged; release → commit next edge.
REQ-039 5 entries, 2 done, flush with simultaneous alloc_valid and wb_reg → count=0, commit_valid=0, next alloc_index=0.
REQ-040 wb_reg to invalid index 6 while count=2 → no state change; rst_n pulsed mid-stream → outputs zero asynchronously.
